// File: rtl/alu_result_monitor.sv
// Buffers ALU {result, flag} pairs in a small FIFO with a sticky overrun flag.
// Define ALU_RESULT_MONITOR_STATS_EN to enable the ERR/OVERFLOW event counters.
module alu_result_monitor #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_valid,
    input  logic signed [WIDTH-1:0]  i_result,
    input  logic [3:0]               i_flag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_result,
    output logic [3:0]               o_flag,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overrun,
    output logic [7:0]               o_err_cnt,
    output logic [7:0]               o_ovf_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [WIDTH+3:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [1:0]       state_q, state_d;
    logic             overrun_q, overrun_d;
    logic             push, pop, drop;

    assign pop  = (state_q != ST_EMPTY) && i_ready;
    assign push = i_valid && ((state_q != ST_FULL) || pop);
    assign drop = i_valid && !push;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = overrun_q | drop;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // State is a pure function of the next occupancy.
        if (level_d == '0)
            state_d = ST_EMPTY;
        else if (level_d == LW'(DEPTH))
            state_d = ST_FULL;
        else
            state_d = ST_PARTIAL;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= ST_EMPTY;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset: the head is masked while EMPTY.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {i_result, i_flag};
    end

    always_comb begin
        o_valid  = (state_q != ST_EMPTY);
        o_result = '0;
        o_flag   = '0;
        if (o_valid) begin
            o_result = mem_q[rd_ptr_q][WIDTH+3:4];
            o_flag   = mem_q[rd_ptr_q][3:0];
        end
    end

    assign o_level   = level_q;
    assign o_overrun = overrun_q;

`ifdef ALU_RESULT_MONITOR_STATS_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push && i_flag[0] && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
        if (push && i_flag[3] && (ovf_cnt_q != 8'hff)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            err_cnt_q <= '0;
            ovf_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign o_err_cnt = err_cnt_q;
    assign o_ovf_cnt = ovf_cnt_q;
`else
    assign o_err_cnt = 8'd0;
    assign o_ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_result_monitor.sv
// Directed-vector bench for alu_result_monitor (WIDTH=4, DEPTH=4).
module tb_alu_result_monitor;

    logic        clk;
    logic        rstn;
    logic        valid_in;
    logic [3:0]  result_in;
    logic [3:0]  flag_in;
    logic        valid_out;
    logic        ready;
    logic [3:0]  result_out;
    logic [3:0]  flag_out;
    logic [2:0]  level;
    logic        overrun;
    logic [7:0]  err_cnt;
    logic [7:0]  ovf_cnt;

    int checks = 0;
    int errors = 0;

    alu_result_monitor #(
        .WIDTH(4),
        .DEPTH(4)
    ) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_valid   (valid_in),
        .i_result  (result_in),
        .i_flag    (flag_in),
        .o_valid   (valid_out),
        .i_ready   (ready),
        .o_result  (result_out),
        .o_flag    (flag_out),
        .o_level   (level),
        .o_overrun (overrun),
        .o_err_cnt (err_cnt),
        .o_ovf_cnt (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] r, input logic [3:0] f);
        valid_in  = 1'b1;
        result_in = r;
        flag_in   = f;
        step();
        valid_in  = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rstn = 1'b0;
        for (int i = 0; i < cycles; i++) step();
        rstn = 1'b1;
    endtask

    logic [7:0] exp_err;
    logic [7:0] exp_ovf;

    initial begin
        rstn = 1'b1; valid_in = 1'b0; result_in = '0; flag_in = '0; ready = 1'b0;
        #2;

        // Reset
        do_reset(2);
        check("rst_valid", valid_out, 0);
        check("rst_level", level, 0);
        check("rst_overrun", overrun, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_result", result_out, 0);
        check("rst_flag", flag_out, 0);

        // Pass-through; ready=1 while empty must not pop
        ready = 1'b1;
        push(4'd2, 4'b0100);
        check("pt_valid", valid_out, 1);
        check("pt_result", result_out, 2);
        check("pt_flag", flag_out, 4'b0100);
        check("pt_level", level, 1);
        step();
        check("pt_valid_after", valid_out, 0);
        check("pt_result_empty", result_out, 0);

        // Fill and overrun
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(4'(i), 4'b0000);
        check("fill_level", level, 4);
        check("fill_overrun", overrun, 1);
        check("fill_head_hold", result_out, 1);
        step();
        check("fill_head_hold2", result_out, 1);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_order", result_out, i);
            step();
        end
        check("drain_empty", valid_out, 0);
        check("drain_level", level, 0);
        check("overrun_sticky", overrun, 1);

        // Push and pop while full
        do_reset(1);
        check("rst2_overrun", overrun, 0);
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(4'(i), 4'b0000);
        check("full_level", level, 4);
        ready = 1'b1;
        push(4'd5, 4'b0000);
        check("pp_level", level, 4);
        check("pp_head", result_out, 2);
        push(4'd6, 4'b0000);
        check("pp_level2", level, 4);
        check("pp_overrun", overrun, 0);
        for (int i = 3; i <= 6; i++) begin
            check("pp_order", result_out, i);
            step();
        end
        check("pp_empty", valid_out, 0);

        // Counters: 3 pushes with ERR|OVERFLOW, then a dropped one
`ifdef ALU_RESULT_MONITOR_STATS_EN
        exp_err = 8'd3; exp_ovf = 8'd3;
`else
        exp_err = 8'd0; exp_ovf = 8'd0;
`endif
        do_reset(1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) push(4'd1, 4'b1001);
        check("cnt_err3", err_cnt, exp_err);
        check("cnt_ovf3", ovf_cnt, exp_ovf);
        push(4'd1, 4'b1001);
        push(4'd1, 4'b1001);
        check("cnt_drop_overrun", overrun, 1);
`ifdef ALU_RESULT_MONITOR_STATS_EN
        exp_err = 8'd4; exp_ovf = 8'd4;
`endif
        check("cnt_err_drop", err_cnt, exp_err);
        check("cnt_ovf_drop", ovf_cnt, exp_ovf);

        // Saturation: 300 ERR-only pushes with ready=1 all succeed
        ready = 1'b1;
        valid_in = 1'b1; result_in = 4'd3; flag_in = 4'b0001;
        for (int i = 0; i < 300; i++) step();
        valid_in = 1'b0;
`ifdef ALU_RESULT_MONITOR_STATS_EN
        exp_err = 8'd255;
`endif
        check("cnt_err_sat", err_cnt, exp_err);
        check("cnt_ovf_hold", ovf_cnt, exp_ovf);

        // Mid-stream reset
        do_reset(1);
        ready = 1'b0;
        push(4'd7, 4'b0000);
        push(4'd8, 4'b0000);
        push(4'd9, 4'b0000);
        check("mid_level3", level, 3);
        rstn = 1'b0;
        valid_in = 1'b1; result_in = 4'd11;
        step();
        valid_in = 1'b0;
        rstn = 1'b1;
        check("mid_rst_level", level, 0);
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_result", result_out, 0);
        push(4'd10, 4'b0010);
        check("mid_first_result", result_out, 10);
        check("mid_first_flag", flag_out, 4'b0010);
        check("mid_first_level", level, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_monitor.md
ALU_RESULT_MONITOR -- requirements
Module: alu_result_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the ALU result word.
REQ-002 SHALL have parameter DEPTH, default 4: number of buffer entries; must be a power of 2 and at least 2.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port i_valid, input, 1 bit: the ALU result and flags are valid this cycle.
REQ-006 SHALL have port i_result, input, WIDTH bits, signed: the ALU result.
REQ-007 SHALL have port i_flag, input, 4 bits: ALU flags; bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW.
REQ-008 SHALL have port o_valid, output, 1 bit: the buffer head is available.
REQ-009 SHALL have port i_ready, input, 1 bit: the consumer accepts the head entry.
REQ-010 SHALL have port o_result, output, WIDTH bits: the head result.
REQ-011 SHALL have port o_flag, output, 4 bits: the head flags.
REQ-012 SHALL have port o_level, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have port o_overrun, output, 1 bit: sticky flag meaning an input was dropped.
REQ-014 SHALL have ports o_err_cnt and o_ovf_cnt, outputs, 8 bits each: event counters.

Function
REQ-015 SHALL buffer {i_result, i_flag} pairs in a first-in, first-out (FIFO) buffer of DEPTH entries, using read and write pointers that wrap modulo DEPTH.
REQ-016 SHALL perform a push when i_valid=1 and the buffer is not full, or when i_valid=1, the buffer is full and a pop occurs in the same cycle.
REQ-017 SHALL perform a pop when o_valid=1 and i_ready=1.
REQ-018 SHALL implement a state machine with states EMPTY, PARTIAL and FULL, encoded from o_level: 0 is EMPTY, DEPTH is FULL, anything else is PARTIAL.
REQ-019 SHALL make state transitions as follows:
- push only: EMPTY→PARTIAL, PARTIAL→PARTIAL or FULL.
- pop only: FULL→PARTIAL, PARTIAL→PARTIAL or EMPTY.
- simultaneous push and pop: state unchanged.
REQ-020 SHALL drive o_valid=1 exactly when the state is not EMPTY.
REQ-021 SHALL present the head entry on o_result and o_flag, and hold them stable while o_valid=1 and i_ready=0.
REQ-022 SHALL have push-to-output latency of 1 cycle: a push into EMPTY at edge N gives o_valid=1 after edge N.
REQ-023 SHALL NOT pop in EMPTY even if i_ready=1; a push in that cycle proceeds normally.
REQ-024 SHALL drop the input and set o_overrun=1 when i_valid=1 in FULL with no pop in the same cycle; o_overrun SHALL stay 1 until reset.
REQ-025 SHALL increment o_err_cnt on every push with i_flag[0]=1, saturating at 255.
REQ-026 SHALL increment o_ovf_cnt on every push with i_flag[3]=1, saturating at 255.
REQ-027 SHALL NOT count dropped inputs in either counter.
REQ-028 SHALL not provide backpressure to the ALU; the ALU has no stall input.

Reset
REQ-029 SHALL, when i_rstn=0 at a rising edge, clear: both pointers, o_level (to 0), o_valid (to 0), o_overrun (to 0), o_err_cnt (to 0), o_ovf_cnt (to 0); the state returns to EMPTY.
REQ-030 SHALL drive o_result and o_flag to 0 while in EMPTY, including after reset.
REQ-031 SHALL give reset priority over any push or pop in the same cycle, including mid-stream; buffered entries are discarded.

Configuration
REQ-032 SHALL, when macro ALU_RESULT_MONITOR_STATS_EN is defined, include the saturating counters described in REQ-025 to REQ-027.
REQ-033 SHALL, when ALU_RESULT_MONITOR_STATS_EN is undefined, omit the counter logic and tie o_err_cnt and o_ovf_cnt to 0; all other behaviour is unchanged.

Verification
REQ-034 SHALL cover reset: after 2 cycles with i_rstn=0, o_valid=0, o_level=0, o_overrun=0 and both counters=0.
REQ-035 SHALL cover single pass-through: push result 4'b0010, flag 4'b0100 with i_ready=1 -> the next cycle shows o_valid=1, o_result=2, o_flag=4'b0100; the following cycle shows o_valid=0.
REQ-036 SHALL cover fill and overrun: i_ready=0, 5 pushes of values 1..5 -> o_level=4 and o_overrun=1; draining then yields 1, 2, 3, 4 in order.
REQ-037 SHALL cover push and pop while FULL: while FULL with i_valid=1 and i_ready=1 -> o_level stays 4, o_overrun stays 0, and the order is preserved.
REQ-038 SHALL cover counters: 3 pushes with flag 4'b1001 -> o_err_cnt=3 and o_ovf_cnt=3 with the macro defined, and both 0 without it; 300 ERR pushes -> o_err_cnt=255.
REQ-039 SHALL cover mid-stream reset: with 3 entries buffered, assert i_rstn=0 for 1 cycle -> the buffer is EMPTY and the next push is the first entry returned.
